// File: rtl/control.sv
// control: registered 16-bit microinstruction word decoded into datapath strobes.
// Optional CONTROL_ILLEGAL_EN adds an `illegal` output for reserved load code / nonzero W[1:0].
module control (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] uinstr,
    output logic        EO_bar,
    output logic        PO_bar,
    output logic        IOH_bar,
    output logic        IOL_bar,
    output logic        XO_bar,
    output logic        YO_bar,
    output logic        RO,
    output logic        DO,
    output logic        RT,
    output logic        PP,
    output logic        MI,
    output logic        RI,
    output logic        DI,
    output logic        II_bar,
    output logic        XI_bar,
    output logic        YI_bar,
    output logic        JC,
    output logic        JZ,
    output logic        JGT,
    output logic        JLT,
`ifdef CONTROL_ILLEGAL_EN
    output logic        illegal,
`endif
    output logic [5:0]  ALU_flags
);

    logic [15:0] w_q, w_d;
    logic        non_eo;
    logic [2:0]  osel, isel;

    assign w_d    = uinstr;
    assign non_eo = w_q[15];
    assign osel   = w_q[14:12];
    assign isel   = w_q[8:6];

    // Word register; reset parks it on a word that decodes to all-inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) w_q <= 16'hF000;
        else       w_q <= w_d;
    end

    // Pure decode of the held word; at most one bus driver and one load at a time.
    always_comb begin
        EO_bar    = non_eo;
        PO_bar    = !(non_eo && osel == 3'd0);
        IOH_bar   = !(non_eo && osel == 3'd1);
        IOL_bar   = !(non_eo && osel == 3'd2);
        RO        = non_eo && osel == 3'd3;
        XO_bar    = !(non_eo && osel == 3'd4);
        YO_bar    = !(non_eo && osel == 3'd5);
        DO        = non_eo && osel == 3'd6;
        RT        = non_eo && w_q[11];
        PP        = non_eo && w_q[10];
        ALU_flags = non_eo ? 6'd0 : w_q[14:9];
        MI        = isel == 3'd1;
        II_bar    = isel != 3'd2;
        RI        = isel == 3'd3;
        XI_bar    = isel != 3'd4;
        YI_bar    = isel != 3'd5;
        DI        = isel == 3'd6;
        JC        = w_q[5];
        JZ        = w_q[4];
        JGT       = w_q[3];
        JLT       = w_q[2];
    end

`ifdef CONTROL_ILLEGAL_EN
    // Flags the reserved load code and any use of the spare low bits.
    always_comb begin
        illegal = (isel == 3'b111) || (w_q[1:0] != 2'b00);
    end
`else
    logic unused_bits;
    assign unused_bits = ^w_q[1:0];
`endif

endmodule

// File: tb/tb_control.sv
// tb_control: directed self-checking bench for the control microinstruction decoder.
module tb_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] uinstr = 16'h0000;
    logic EO_bar, PO_bar, IOH_bar, IOL_bar, XO_bar, YO_bar, RO, DO, RT, PP;
    logic MI, RI, DI, II_bar, XI_bar, YI_bar, JC, JZ, JGT, JLT;
    logic [5:0] ALU_flags;
`ifdef CONTROL_ILLEGAL_EN
    logic illegal;
`endif
    logic [25:0] obs;
    int errors = 0;
    int checks = 0;

    localparam logic [25:0] T_EO  = 26'd1 << 25;
    localparam logic [25:0] T_PO  = 26'd1 << 24;
    localparam logic [25:0] T_IOH = 26'd1 << 23;
    localparam logic [25:0] T_IOL = 26'd1 << 22;
    localparam logic [25:0] T_XO  = 26'd1 << 21;
    localparam logic [25:0] T_YO  = 26'd1 << 20;
    localparam logic [25:0] T_RO  = 26'd1 << 19;
    localparam logic [25:0] T_DO  = 26'd1 << 18;
    localparam logic [25:0] T_RT  = 26'd1 << 17;
    localparam logic [25:0] T_PP  = 26'd1 << 16;
    localparam logic [25:0] T_MI  = 26'd1 << 15;
    localparam logic [25:0] T_RI  = 26'd1 << 14;
    localparam logic [25:0] T_DI  = 26'd1 << 13;
    localparam logic [25:0] T_II  = 26'd1 << 12;
    localparam logic [25:0] T_XI  = 26'd1 << 11;
    localparam logic [25:0] T_YI  = 26'd1 << 10;
    localparam logic [25:0] T_JC  = 26'd1 << 9;
    localparam logic [25:0] T_JZ  = 26'd1 << 8;
    localparam logic [25:0] T_JGT = 26'd1 << 7;
    localparam logic [25:0] T_JLT = 26'd1 << 6;
    localparam logic [25:0] IDLE  = T_EO | T_PO | T_IOH | T_IOL | T_XO | T_YO | T_II | T_XI | T_YI;
    localparam logic [25:0] OUT_T [8] = '{T_PO, T_IOH, T_IOL, T_RO, T_XO, T_YO, T_DO, 26'd0};
    localparam logic [25:0] IN_T  [8] = '{26'd0, T_MI, T_II, T_RI, T_XI, T_YI, T_DI, 26'd0};

    control dut (
        .clk(clk), .reset(reset), .uinstr(uinstr),
        .EO_bar(EO_bar), .PO_bar(PO_bar), .IOH_bar(IOH_bar), .IOL_bar(IOL_bar),
        .XO_bar(XO_bar), .YO_bar(YO_bar), .RO(RO), .DO(DO), .RT(RT), .PP(PP),
        .MI(MI), .RI(RI), .DI(DI), .II_bar(II_bar), .XI_bar(XI_bar), .YI_bar(YI_bar),
        .JC(JC), .JZ(JZ), .JGT(JGT), .JLT(JLT),
`ifdef CONTROL_ILLEGAL_EN
        .illegal(illegal),
`endif
        .ALU_flags(ALU_flags)
    );

    always #5 clk = ~clk;

    assign obs = {EO_bar, PO_bar, IOH_bar, IOL_bar, XO_bar, YO_bar, RO, DO, RT, PP,
                  MI, RI, DI, II_bar, XI_bar, YI_bar, JC, JZ, JGT, JLT, ALU_flags};

    task automatic chk(input string tag, input logic [25:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, e);
        end
    endtask

`ifdef CONTROL_ILLEGAL_EN
    task automatic chk_ill(input string tag, input logic e);
        checks++;
        assert (illegal === e) else begin
            errors++;
            $error("FAIL %s: illegal got %b expected %b", tag, illegal, e);
        end
    endtask
`endif

    task automatic step(input logic [15:0] w);
        @(negedge clk);
        uinstr = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("reset_no_clk", IDLE);
`ifdef CONTROL_ILLEGAL_EN
        chk_ill("reset_illegal", 1'b0);
`endif
        @(negedge clk);
        uinstr = 16'h8000;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_po", IDLE ^ T_PO);
        step(16'h1020);
        chk("eo_jc_flags08", IDLE ^ T_EO ^ T_JC | 26'h08);
        step(16'h7E40);
        chk("eo_mi_flags3f", IDLE ^ T_EO ^ T_MI | 26'h3F);
        step(16'h0C00);
        chk("eo_no_rt_pp", IDLE ^ T_EO | 26'h06);
        step(16'hADC0);
        chk("iol_rt_pp_resv", IDLE ^ T_IOL ^ T_RT ^ T_PP);
`ifdef CONTROL_ILLEGAL_EN
        chk_ill("resv_illegal", 1'b1);
`endif
        step(16'hB5C0);
        chk("ro_pp_resv", IDLE ^ T_RO ^ T_PP);
        step(16'hF800);
        chk("rt_only", IDLE ^ T_RT);
        step(16'h8020);
        chk("jc", IDLE ^ T_PO ^ T_JC);
        step(16'h8010);
        chk("jz", IDLE ^ T_PO ^ T_JZ);
        step(16'h8008);
        chk("jgt", IDLE ^ T_PO ^ T_JGT);
        step(16'h8004);
        chk("jlt", IDLE ^ T_PO ^ T_JLT);
        step(16'h8003);
        chk("low_bits_ignored", IDLE ^ T_PO);
`ifdef CONTROL_ILLEGAL_EN
        chk_ill("low_bits_illegal", 1'b1);
`endif
        for (int o = 0; o < 8; o++) begin
            for (int i = 0; i < 8; i++) begin
                step(16'h8000 | 16'(o << 12) | 16'(i << 6));
                chk($sformatf("sweep_o%0d_i%0d", o, i), IDLE ^ OUT_T[o] ^ IN_T[i]);
`ifdef CONTROL_ILLEGAL_EN
                chk_ill($sformatf("sweep_ill_i%0d", i), i == 7);
`endif
            end
        end
        step(16'hC000);
        chk("xo_before_reset", IDLE ^ T_XO);
        @(negedge clk);
        uinstr = 16'h8000;
        #1 reset = 1'b1;
        #1;
        chk("reset_midstream", IDLE);
        @(posedge clk);
        #1;
        chk("reset_held", IDLE);
        @(negedge clk);
        reset = 1'b0;
        uinstr = 16'hC000;
        #1;
        chk("released_no_edge", IDLE);
        @(posedge clk);
        #1;
        chk("after_release", IDLE ^ T_XO);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
